// File: rtl/seq_trojan_adder.sv
// Registered W-bit adder with a valid/ready stream and an embedded sequential Trojan.
// The Trojan arms on a secret operand sequence or a transaction-count time bomb.
module seq_trojan_adder #(
  parameter int               WIDTH        = 4,
  parameter int               TROJAN_EN    = 1,
  parameter int               TRIG_MODE    = 0,
  parameter logic [WIDTH-1:0] KEY0         = WIDTH'(8),
  parameter logic [WIDTH-1:0] KEY1         = WIDTH'(1),
  parameter logic [WIDTH-1:0] KEY2         = WIDTH'(8),
  parameter int               BOMB_COUNT   = 16,
  parameter logic [WIDTH:0]   PAYLOAD_MASK = (WIDTH+1)'(1),
  parameter int               PAYLOAD_LEN  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             trojan_active
);

  localparam int BW = $clog2(BOMB_COUNT + 1);
  localparam int PW = $clog2(PAYLOAD_LEN + 1);
  localparam logic [BW-1:0] BOMB_LAST = BW'(BOMB_COUNT - 1);
  localparam logic [PW-1:0] PAY_INIT  = PW'(PAYLOAD_LEN);
  localparam logic [PW-1:0] PAY_LAST  = PW'(1);

  typedef enum logic [1:0] {IDLE, S1, S2, ARMED} state_t;

  state_t          state;
  logic [BW-1:0]   bomb_cnt;
  logic [PW-1:0]   pay_cnt;
  logic            accept;
  logic [WIDTH:0]  clean;

  assign in_ready      = !out_valid || out_ready;
  assign accept        = in_valid && in_ready;
  assign clean         = {1'b0, a} + {1'b0, b};
  assign trojan_active = (state == ARMED);

  // Output register: the payload applies when the FSM is already ARMED at accept time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      sum       <= (state == ARMED) ? (clean ^ PAYLOAD_MASK) : clean;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Trigger FSM; only accepted transactions advance it, and the golden build never leaves IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      bomb_cnt <= '0;
      pay_cnt  <= '0;
    end else if (accept && (TROJAN_EN != 0)) begin
      case (state)
        IDLE: begin
          if (TRIG_MODE != 0) begin
            if (bomb_cnt == BOMB_LAST) begin
              state    <= ARMED;
              bomb_cnt <= '0;
              pay_cnt  <= PAY_INIT;
            end else begin
              bomb_cnt <= bomb_cnt + 1'b1;
            end
          end else if (a == KEY0) begin
            state <= S1;
          end
        end
        S1: begin
          if (a == KEY1)      state <= S2;
          else if (a == KEY0) state <= S1;
          else                state <= IDLE;
        end
        S2: begin
          if (a == KEY2) begin
            state   <= ARMED;
            pay_cnt <= PAY_INIT;
          end else if (a == KEY0) begin
            state <= S1;
          end else begin
            state <= IDLE;
          end
        end
        ARMED: begin
          if (pay_cnt == PAY_LAST) begin
            state   <= IDLE;
            pay_cnt <= '0;
          end else begin
            pay_cnt <= pay_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
